// File: rtl/memory_arbiter_pkg.sv
// Shared types and the winner-select helper for memory_arbiter.
package memory_arbiter_pkg;

  typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;
  typedef enum logic {PORT_FETCH, PORT_DATA} arb_port_t;

  // Single requester wins outright; a tie goes to tie_winner
  function automatic arb_port_t arb_pick(input logic fetch_present,
                                         input logic data_present,
                                         input arb_port_t tie_winner);
    if (fetch_present && data_present) return tie_winner;
    if (data_present) return PORT_DATA;
    return PORT_FETCH;
  endfunction

endpackage

// File: rtl/memory_io.sv
// Memory port payload types shared by the core and the memory instance.
package memory_io;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_BYTES  = MEM_DATA_W / 8;

  typedef struct packed {
    logic                  valid;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
    logic [MEM_BYTES-1:0]  do_read;
    logic [MEM_BYTES-1:0]  do_write;
  } memory_io_req;

  typedef struct packed {
    logic                  valid;
    logic [MEM_DATA_W-1:0] data;
  } memory_io_rsp;

  localparam memory_io_req memory_io_no_req = '0;
  localparam memory_io_rsp memory_io_no_rsp = '0;

  // True when any byte lane is enabled
  function automatic logic is_any_byte(input logic [MEM_BYTES-1:0] be);
    return |be;
  endfunction

endpackage

// File: rtl/memory_arbiter_pick.sv
// Combinational winner select between fetch and data ports.
// MEMORY_ARBITER_RR_EN: ties alternate against last_grant; otherwise fixed by fetch_priority.
module memory_arbiter_pick
  import memory_arbiter_pkg::*;
#(
  parameter bit fetch_priority = 1'b1
) (
  input  logic      fetch_present,
  input  logic      data_present,
  input  arb_port_t last_grant,
  output arb_port_t winner
);

  arb_port_t tie_winner;

`ifdef MEMORY_ARBITER_RR_EN
  localparam bit unused_fetch_priority = fetch_priority;
  // Round-robin: the port that did not win last time takes the tie
  assign tie_winner = (last_grant == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  // Fixed priority: tie goes to the configured port
  assign tie_winner = fetch_priority ? PORT_FETCH : PORT_DATA;
`endif

  assign winner = arb_pick(fetch_present, data_present, tie_winner);

endmodule

// File: rtl/memory_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction outstanding.
// Optional MEMORY_ARBITER_RR_EN selects round-robin tie breaking.
module memory_arbiter
  import memory_io::*;
  import memory_arbiter_pkg::*;
#(
  parameter bit          fetch_priority = 1'b1,
  parameter int unsigned rsp_timeout    = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  memory_io_req fetch_req,
  output logic         fetch_ready,
  output memory_io_rsp fetch_rsp,
  input  memory_io_req data_req,
  output logic         data_ready,
  output memory_io_rsp data_rsp,
  output memory_io_req mem_req,
  input  memory_io_rsp mem_rsp,
  output logic         err_timeout,
  output logic         err_stray_rsp
);

  localparam int unsigned CNT_W      = (rsp_timeout == 0) ? 1 : $clog2(rsp_timeout + 1);
  localparam bit          TIMEOUT_EN = (rsp_timeout != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((rsp_timeout == 0) ? 0 : rsp_timeout - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_t       state;
  arb_port_t        owner;
  arb_port_t        pick_last;
  arb_port_t        winner;
  logic [CNT_W-1:0] cnt;
  logic             fetch_present;
  logic             data_present;
  logic             grant;

`ifdef MEMORY_ARBITER_RR_EN
  arb_port_t last_grant;
  assign pick_last = last_grant;
`else
  assign pick_last = PORT_DATA;
`endif

  assign fetch_present = fetch_req.valid &&
                         (is_any_byte(fetch_req.do_read) || is_any_byte(fetch_req.do_write));
  assign data_present  = data_req.valid &&
                         (is_any_byte(data_req.do_read) || is_any_byte(data_req.do_write));

  // A new request can issue from IDLE or in the cycle the outstanding response returns
  assign grant = !reset && (fetch_present || data_present) &&
                 ((state == ARB_IDLE) || (mem_rsp.valid == 1'b1));

  memory_arbiter_pick #(
    .fetch_priority (fetch_priority)
  ) u_pick (
    .fetch_present (fetch_present),
    .data_present  (data_present),
    .last_grant    (pick_last),
    .winner        (winner)
  );

  // Request issue, response routing and timeout pulse
  always_comb begin
    fetch_ready = 1'b0;
    data_ready  = 1'b0;
    mem_req     = memory_io_no_req;
    fetch_rsp   = memory_io_no_rsp;
    data_rsp    = memory_io_no_rsp;
    err_timeout = 1'b0;
    if (!reset) begin
      if (state == ARB_WAIT && mem_rsp.valid) begin
        if (owner == PORT_FETCH) fetch_rsp = mem_rsp;
        else                     data_rsp  = mem_rsp;
      end
      if (grant) begin
        if (winner == PORT_FETCH) begin
          fetch_ready = 1'b1;
          mem_req     = fetch_req;
        end else begin
          data_ready = 1'b1;
          mem_req    = data_req;
        end
      end
      if (TIMEOUT_EN && state == ARB_WAIT && !mem_rsp.valid && cnt == CNT_LAST)
        err_timeout = 1'b1;
    end
  end

  // State, owner, timeout counter and sticky stray flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ARB_IDLE;
      owner         <= PORT_FETCH;
      cnt           <= '0;
      err_stray_rsp <= 1'b0;
`ifdef MEMORY_ARBITER_RR_EN
      last_grant    <= PORT_DATA;
`endif
    end else begin
      if (state == ARB_IDLE && mem_rsp.valid) err_stray_rsp <= 1'b1;
      if (grant) begin
        state <= ARB_WAIT;
        owner <= winner;
        cnt   <= '0;
`ifdef MEMORY_ARBITER_RR_EN
        last_grant <= winner;
`endif
      end else if (state == ARB_WAIT) begin
        if (mem_rsp.valid || err_timeout) begin
          state <= ARB_IDLE;
          cnt   <= '0;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: stimulus queues expected grants/responses,
// a negedge monitor pops and compares them.
module tb_memory_arbiter;
  import memory_io::*;
  import memory_arbiter_pkg::*;

`ifdef MEMORY_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk;
  logic         reset;
  memory_io_req fetch_req, data_req, mem_req;
  memory_io_rsp fetch_rsp, data_rsp, mem_rsp;
  logic         fetch_ready, data_ready, err_timeout, err_stray_rsp;

  logic         respond_en;
  logic         inject;
  logic [31:0]  mem [0:255];

  int checks;
  int failures;

  arb_port_t   grant_q[$];
  logic [31:0] fetch_q[$];
  logic [31:0] data_q[$];

  memory_arbiter #(
    .fetch_priority (1'b1),
    .rsp_timeout    (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_req     (fetch_req),
    .fetch_ready   (fetch_ready),
    .fetch_rsp     (fetch_rsp),
    .data_req      (data_req),
    .data_ready    (data_ready),
    .data_rsp      (data_rsp),
    .mem_req       (mem_req),
    .mem_rsp       (mem_rsp),
    .err_timeout   (err_timeout),
    .err_stray_rsp (err_stray_rsp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic memory_io_req rd(input logic [31:0] a);
    memory_io_req r;
    r = '0;
    r.valid = 1'b1; r.addr = a; r.do_read = 4'hF;
    return r;
  endfunction

  function automatic memory_io_req wr(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] be);
    memory_io_req r;
    r = '0;
    r.valid = 1'b1; r.addr = a; r.data = d; r.do_write = be;
    return r;
  endfunction

  // Memory model: answers one cycle after issue; can be silenced or made to inject a stray rsp
  initial begin
    memory_io_rsp r;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'hDEADBEEF;  // 0x100
    mem[8'h80] = 32'h12345678;  // 0x200
    mem[8'hC0] = 32'hCAFEF00D;  // 0x300
    mem[8'h10] = 32'h11223344;  // 0x040
    mem_rsp = '0;
    forever begin
      @(posedge clk);
      r = '0;
      if (mem_req.valid && respond_en) begin
        r.valid = 1'b1;
        for (int b = 0; b < 4; b++)
          if (mem_req.do_write[b]) mem[mem_req.addr[9:2]][8*b +: 8] = mem_req.data[8*b +: 8];
        if (|mem_req.do_read) r.data = mem[mem_req.addr[9:2]];
      end else if (inject) begin
        r.valid = 1'b1;
        r.data  = 32'h0BAD0BAD;
      end
      mem_rsp <= r;
    end
  end

  // Monitor: every grant and routed response must match the head of its queue
  always @(negedge clk) begin
    arb_port_t   ep;
    logic [31:0] ed;
    if (fetch_ready && data_ready) chk("both_ready", 32'd1, 32'd0);
    if (fetch_ready || data_ready) begin
      if (grant_q.size() == 0) chk("grant_unexpected", 32'd1, 32'd0);
      else begin
        ep = grant_q.pop_front();
        chk("grant_port", 32'(data_ready), 32'(ep == PORT_DATA));
      end
    end
    if (fetch_rsp.valid) begin
      if (fetch_q.size() == 0) chk("fetch_rsp_unexpected", fetch_rsp.data, 32'hFFFF_FFFF);
      else begin
        ed = fetch_q.pop_front();
        chk("fetch_rsp_data", fetch_rsp.data, ed);
      end
    end
    if (data_rsp.valid) begin
      if (data_q.size() == 0) chk("data_rsp_unexpected", data_rsp.data, 32'hFFFF_FFFF);
      else begin
        ed = data_q.pop_front();
        chk("data_rsp_data", data_rsp.data, ed);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  // Bounded wait for a grant on one port; returns just after the accepting edge
  task automatic wait_grant(input bit is_data, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = is_data ? data_ready : fetch_ready;
    end
    chk(name, 32'(seen), 32'd1);
    step(1);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; respond_en = 1'b1; inject = 1'b0;
    fetch_req = memory_io_no_req; data_req = memory_io_no_req;
    step(2);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {30'd0, fetch_ready, data_ready}, 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req.valid), 32'd0);
    chk("rst_rsp_valid", {30'd0, fetch_rsp.valid, data_rsp.valid}, 32'd0);
    chk("rst_errors", {30'd0, err_timeout, err_stray_rsp}, 32'd0);
    step(1);

    // 1: fetch read 0x100, response next cycle
    grant_q.push_back(PORT_FETCH); fetch_q.push_back(32'hDEADBEEF);
    fetch_req = rd(32'h100);
    wait_grant(1'b0, "t1_grant");
    fetch_req = memory_io_no_req;
    @(negedge clk);
    chk("t1_rsp_latency", 32'(fetch_rsp.valid), 32'd1);
    step(3);

    // 2: simultaneous requests, fetch first, data issued back-to-back
    do_reset();
    grant_q.push_back(PORT_FETCH); grant_q.push_back(PORT_DATA);
    fetch_q.push_back(32'h12345678); data_q.push_back(32'hCAFEF00D);
    fetch_req = rd(32'h200); data_req = rd(32'h300);
    wait_grant(1'b0, "t2_fetch_grant");
    fetch_req = memory_io_no_req;
    @(negedge clk);
    chk("t2_back_to_back", {30'd0, data_ready, fetch_rsp.valid}, 32'd3);
    step(1);
    data_req = memory_io_no_req;
    step(3);

    // 3: both held for six grants
    do_reset();
    for (int g = 0; g < 6; g++) begin
      if (RR && (g % 2 == 1)) begin
        grant_q.push_back(PORT_DATA); data_q.push_back(32'hCAFEF00D);
      end else begin
        grant_q.push_back(PORT_FETCH); fetch_q.push_back(32'hDEADBEEF);
      end
    end
    fetch_req = rd(32'h100); data_req = rd(32'h300);
    step(6);
    fetch_req = memory_io_no_req; data_req = memory_io_no_req;
    step(3);
    chk("t3_grants_left", 32'(grant_q.size()), 32'd0);

    // 4: partial write then readback
    do_reset();
    grant_q.push_back(PORT_DATA); data_q.push_back(32'h0);
    data_req = wr(32'h40, 32'hAABBCCDD, 4'b0011);
    wait_grant(1'b1, "t4_write_grant");
    data_req = memory_io_no_req;
    @(negedge clk);
    chk("t4_write_rsp", 32'(data_rsp.valid), 32'd1);
    step(2);
    grant_q.push_back(PORT_FETCH); fetch_q.push_back(32'h1122CCDD);
    fetch_req = rd(32'h40);
    wait_grant(1'b0, "t4_read_grant");
    fetch_req = memory_io_no_req;
    step(3);

    // 5: memory silent -> timeout pulse 4 cycles after issue, late rsp is stray
    do_reset();
    respond_en = 1'b0;
    grant_q.push_back(PORT_FETCH);
    fetch_req = rd(32'h80);
    wait_grant(1'b0, "t5_grant");
    fetch_req = memory_io_no_req;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("t5_timeout_c%0d", k), 32'(err_timeout), 32'(k == 4));
    end
    @(negedge clk);
    chk("t5_state_idle", 32'(dut.state == ARB_IDLE), 32'd1);
    chk("t5_no_stray_yet", 32'(err_stray_rsp), 32'd0);
    step(1);
    inject = 1'b1;
    step(1);
    inject = 1'b0;
    @(negedge clk);
    chk("t5_stray_not_routed", {30'd0, fetch_rsp.valid, data_rsp.valid}, 32'd0);
    @(negedge clk);
    chk("t5_stray_set", 32'(err_stray_rsp), 32'd1);
    step(1);
    respond_en = 1'b1;

    // 6: reset in WAIT forgets the transaction
    do_reset();
    chk("t6_stray_cleared", 32'(err_stray_rsp), 32'd0);
    respond_en = 1'b0;
    grant_q.push_back(PORT_DATA);
    data_req = rd(32'h300);
    wait_grant(1'b1, "t6_grant");
    data_req = memory_io_no_req;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_reset_ready", {30'd0, fetch_ready, data_ready}, 32'd0);
    chk("t6_reset_mem_req", 32'(mem_req.valid), 32'd0);
    step(1);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_state_idle", 32'(dut.state == ARB_IDLE), 32'd1);
    step(1);
    inject = 1'b1;
    step(1);
    inject = 1'b0;
    @(negedge clk);
    chk("t6_rsp_not_routed", {30'd0, fetch_rsp.valid, data_rsp.valid}, 32'd0);
    @(negedge clk);
    chk("t6_stray_set", 32'(err_stray_rsp), 32'd1);
    respond_en = 1'b1;
    step(2);

    chk("end_grant_q", 32'(grant_q.size()), 32'd0);
    chk("end_fetch_q", 32'(fetch_q.size()), 32'd0);
    chk("end_data_q", 32'(data_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
